// File: rtl/apb_master_queued_pkg.sv
// Shared types for the queued APB requester: transfer FSM states and response codes.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_SLVERR  = 2'b01,
    RSP_DECERR  = 2'b10,
    RSP_TIMEOUT = 2'b11
  } rsp_err_e;

endpackage

// File: rtl/apb_master_queued_if.sv
// Command stream, response stream and APB bus of the queued requester.
interface apb_master_queued_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_strb;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [1:0]              rsp_err;

  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [NUM_SLAVES-1:0]   PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_queued_cmd_fifo.sv
// Synchronous command FIFO; extra pointer MSB distinguishes full from empty.
module apb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  // Push is gated by the registered full flag, so a same-cycle pop never frees a slot early.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/apb_master_queued.sv
// Queued APB5 requester: command FIFO, address decode, one transfer per command.
// Optional wait-state timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_queued
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_SLAVES     = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h0000_1000,
  parameter int                    REGION_LOG2    = 12,
  parameter int                    CMD_DEPTH      = 4,
  parameter logic [2:0]            PPROT_VAL      = 3'b000,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_queued_if.master bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int FIFO_W = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_W;

  if ((DATA_WIDTH % 8) != 0 || NUM_SLAVES < 1 || NUM_SLAVES > 16 || CMD_DEPTH < 2 ||
      (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("apb_master_queued: illegal parameter combination");
  end

  function automatic logic [NUM_SLAVES-1:0] decode_sel(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0]  idx;
    logic [NUM_SLAVES-1:0]  sel;
    idx = (addr - BASE_ADDR) >> REGION_LOG2;
    sel = '0;
    if (addr >= BASE_ADDR) begin
      for (int i = 0; i < NUM_SLAVES; i++) sel[i] = (idx == ADDR_WIDTH'(i));
    end
    return sel;
  endfunction

  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [FIFO_W-1:0]     fifo_head;
  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic [STRB_W-1:0]     head_strb;
  logic [NUM_SLAVES-1:0] head_sel;

  apb_cmd_fifo #(.WIDTH(FIFO_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .push_i  (bus.cmd_valid),
    .wdata_i ({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_strb}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {head_write, head_addr, head_wdata, head_strb} = fifo_head;
  assign head_sel = decode_sel(head_addr);

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            err_q, err_d;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_q, wait_d;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
`ifdef APB_TIMEOUT_EN
    wait_d   = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = head_addr;
          write_d  = head_write;
          wdata_d  = head_wdata;
          strb_d   = head_write ? head_strb : '0;
          sel_d    = head_sel;
          if (|head_sel) begin
            state_d = SETUP;
          end else begin
            err_d   = RSP_DECERR;
            rdata_d = '0;
            state_d = RESP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      ACCESS: begin
        if (bus.PREADY) begin
          err_d   = bus.PSLVERR ? RSP_SLVERR : RSP_OK;
          rdata_d = (!write_q && !bus.PSLVERR) ? bus.PRDATA : '0;
          state_d = RESP;
`ifdef APB_TIMEOUT_EN
        end else if (wait_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This is the TIMEOUT_CYCLES-th wait state: abandon the transfer.
          err_d   = RSP_TIMEOUT;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          wait_d  = wait_q + CNT_W'(1);
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
`ifdef APB_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef APB_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  // Selects and enable derive from the state register so reset drops them at once.
  assign bus.cmd_ready = !fifo_full;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.PADDR     = addr_q;
  assign bus.PSEL      = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
  assign bus.PENABLE   = (state_q == ACCESS);
  assign bus.PWRITE    = write_q;
  assign bus.PWDATA    = wdata_q;
  assign bus.PSTRB     = strb_q;
  assign bus.PPROT     = PPROT_VAL;
endmodule

// File: tb/tb_apb_master_queued.sv
// Scoreboard bench for apb_master_queued with a randomized command stream and APB slave model.
module tb_apb_master_queued;
  localparam int TO_CYCLES = 16;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    bit          write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    bit          err;
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  logic PCLK, PRESETn;
  apb_master_queued_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4)) bus ();

  apb_master_queued dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  int    vecs = 0;
  int    errs = 0;
  plan_t plans[$];
  exp_t  exp_q[$];
  bit    hold_rsp = 1'b0;
  int    xfer_cnt = 0;
  int    last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    vecs++;
    errs++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference model: slave map is four 4 KiB regions starting at 0x1000.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int waits, input bit serr,
                       input logic [31:0] rd);
    plan_t p;
    exp_t  e;
    int    n;
    bit    timed_out;
    timed_out = 1'b0;
`ifdef APB_TIMEOUT_EN
    timed_out = (waits >= TO_CYCLES);
`endif
    if (a >= 32'h1000 && a < 32'h1000 + 4 * 32'h1000) begin
      p.addr  = a;
      p.sel   = 4'(1 << ((a - 32'h1000) / 32'h1000));
      p.write = w;
      p.wdata = d;
      p.strb  = w ? s : 4'h0;
      p.waits = waits;
      p.err   = serr;
      p.rdata = rd;
      if (timed_out)  begin e.err = 2'b11; e.rdata = '0; end
      else if (serr)  begin e.err = 2'b01; e.rdata = '0; end
      else            begin e.err = 2'b00; e.rdata = w ? 32'h0 : rd; end
    end else begin
      e.err   = 2'b10;
      e.rdata = '0;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_strb  = s;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 200) begin
      fail_now("cmd_accept");
    end else begin
      if (e.err != 2'b10) plans.push_back(p);
      exp_q.push_back(e);
    end
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || plans.size() != 0) && n < 3000) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 3000) fail_now("drain");
    repeat (3) @(negedge PCLK);
  endtask

  // APB slave model: checks each SETUP against the next planned transfer and plays its wait states.
  initial begin : slave
    plan_t cur;
    int    rem;
    int    acc;
    bit    active;
    active = 1'b0;
    rem = 0;
    acc = 0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        bus.PREADY = 1'b0;
        active = 1'b0;
      end else if (bus.PSEL != 0 && !bus.PENABLE) begin
        if (plans.size() == 0) begin
          chk("unexpected_psel", 32'(bus.PSEL), 32'h0);
        end else begin
          cur = plans.pop_front();
          chk("psel", 32'(bus.PSEL), 32'(cur.sel));
          chk("paddr", bus.PADDR, cur.addr);
          chk("pwrite", 32'(bus.PWRITE), 32'(cur.write));
          chk("pstrb", 32'(bus.PSTRB), 32'(cur.strb));
          if (cur.write) chk("pwdata", bus.PWDATA, cur.wdata);
          xfer_cnt++;
          active = 1'b1;
          rem = cur.waits;
          acc = 0;
        end
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
      end else if (bus.PSEL != 0 && bus.PENABLE) begin
        acc++;
        if (active) chk("paddr_stable", bus.PADDR, cur.addr);
        bus.PREADY  = (rem == 0);
        bus.PSLVERR = (rem == 0) ? cur.err : 1'b0;
        bus.PRDATA  = (rem == 0) ? cur.rdata : $urandom;
        if (rem > 0) rem--;
      end else begin
        if (active) last_acc = acc;
        active = 1'b0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
      end
    end
  end

  // Response monitor: pops the scoreboard on each handshake.
  initial begin : monitor
    exp_t e;
    bit   nr;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        bus.rsp_ready = 1'b0;
      end else begin
        nr = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
        bus.rsp_ready = nr;
        if (bus.rsp_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
          end else if (nr) begin
            e = exp_q.pop_front();
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] a;
    int          x0;
    PRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_psel", 32'(bus.PSEL), 32'h0);
    chk("rst_penable", 32'(bus.PENABLE), 32'h0);
    chk("rst_paddr", bus.PADDR, 32'h0);
    chk("rst_pprot", 32'(bus.PPROT), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    issue(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0);
    drain();
    chk("t1_access_cycles", 32'(last_acc), 32'd1);

    issue(1'b0, 32'h0000_3008, 32'h1234_5678, 4'hA, 3, 1'b0, 32'hCAFE_BABE);
    drain();
    chk("t2_access_cycles", 32'(last_acc), 32'd4);

    x0 = xfer_cnt;
    issue(1'b0, 32'h0000_0800, 32'h0, 4'h0, 0, 1'b0, 32'h0);
    issue(1'b0, 32'h0000_5000, 32'h0, 4'h0, 0, 1'b0, 32'h0);
    issue(1'b1, 32'h0000_0FFC, 32'h1, 4'h3, 0, 1'b0, 32'h0);
    drain();
    chk("decerr_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    issue(1'b0, 32'h0000_1000, 32'h0, 4'h0, 0, 1'b0, 32'h0101_0101);
    issue(1'b0, 32'h0000_4FFC, 32'h0, 4'h0, 1, 1'b0, 32'h0404_0404);
    issue(1'b0, 32'h0000_1000, 32'h0, 4'h0, 1, 1'b1, 32'h5555_AAAA);
    drain();

    hold_rsp = 1'b1;
    x0 = xfer_cnt;
    for (int i = 0; i < 5; i++)
      issue(1'b1, 32'h1000 + 32'(i % 4) * 32'h1000 + 32'(4 * i), $urandom, 4'(i + 1), 0, 1'b0, 32'h0);
    chk("full_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    repeat (20) @(negedge PCLK);
    chk("held_one_xfer", 32'(xfer_cnt - x0), 32'd1);
    chk("held_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    hold_rsp = 1'b0;
    drain();
    chk("held_all_xfer", 32'(xfer_cnt - x0), 32'd5);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       a = $urandom_range(0, 32'h0FFF) & 32'hFFFF_FFFC;
        1:       a = 32'h5000 + ($urandom & 32'h000F_FFFC);
        default: a = 32'h1000 + 32'($urandom_range(0, 3)) * 32'h1000 + 32'($urandom_range(0, 1023) * 4);
      endcase
      issue(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3),
            ($urandom_range(0, 5) == 0), $urandom);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge PCLK);
    end
    drain();

`ifdef APB_TIMEOUT_EN
    issue(1'b0, 32'h0000_2010, 32'h0, 4'h0, 40, 1'b0, 32'h7777_7777);
    drain();
    chk("timeout_access_cycles", 32'(last_acc), 32'd16);
    issue(1'b0, 32'h0000_2014, 32'h0, 4'h0, 15, 1'b0, 32'h8888_8888);
    drain();
`endif

    // Reset with one response held and two commands still queued.
    hold_rsp = 1'b1;
    issue(1'b0, 32'h0000_1100, 32'h0, 4'h0, 0, 1'b0, 32'h1);
    issue(1'b1, 32'h0000_2100, 32'h2, 4'hF, 0, 1'b0, 32'h0);
    issue(1'b1, 32'h0000_3100, 32'h3, 4'hF, 0, 1'b0, 32'h0);
    repeat (4) @(negedge PCLK);
    chk("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    PRESETn = 1'b0;
    #1;
    chk("rst_flush_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_flush_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    plans.delete();
    exp_q.delete();
    hold_rsp = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    x0 = xfer_cnt;
    repeat (10) @(negedge PCLK);
    chk("rst_flush_no_xfer", 32'(xfer_cnt - x0), 32'd0);

    // Reset in the middle of a long ACCESS phase.
    issue(1'b0, 32'h0000_4020, 32'h0, 4'h0, 1000, 1'b0, 32'h9);
    x0 = 0;
    while (!bus.PENABLE && x0 < 50) begin
      @(negedge PCLK);
      x0++;
    end
    if (x0 >= 50) fail_now("reach_access");
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    chk("midrst_psel", 32'(bus.PSEL), 32'h0);
    chk("midrst_penable", 32'(bus.PENABLE), 32'h0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    plans.delete();
    exp_q.delete();
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);

    issue(1'b0, 32'h0000_1008, 32'h0, 4'h0, 2, 1'b0, 32'hA5A5_0F0F);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
